// File: rtl/video_timing_pkg.sv
// Shared video timing types and default 640x480@60 constants for the DVI output path.
// Reused by the timing generator, test pattern and TMDS blocks.
package video_timing_pkg;

  localparam int COORD_W = 10;

  // 640x480@60 from a 25.2 MHz pixel clock
  localparam int VGA_H_ACTIVE     = 640;
  localparam int VGA_H_FRONT      = 16;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_BACK       = 48;
  localparam int VGA_V_ACTIVE     = 480;
  localparam int VGA_V_FRONT      = 10;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_BACK       = 33;
  localparam int VGA_READ_LATENCY = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic frame_start;
    logic line_start;
  } video_ctrl_t;

  // True when cnt lies in [lo, hi); one extra bit so hi may equal 2**COORD_W
  function automatic logic in_window(input logic [COORD_W-1:0] cnt,
                                     input logic [COORD_W:0]   lo,
                                     input logic [COORD_W:0]   hi);
    return ({1'b0, cnt} >= lo) && ({1'b0, cnt} < hi);
  endfunction

endpackage

// File: rtl/video_timing_gen_ctrl_delay.sv
// DEPTH-stage shift register carrying sync/enable/marker bits alongside the
// framebuffer read latency. Async reset clears every stage so no stale pulse survives.
module video_ctrl_delay
  import video_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  video_ctrl_t din,
  output video_ctrl_t dout
);

  video_ctrl_t [DEPTH-1:0] stages;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock video timing generator: h/v counters, framebuffer read strobes for the
// active area, and vs/hs/de/rgb outputs re-aligned with the returned pixel data.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_FRONT      = VGA_H_FRONT,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BACK       = VGA_H_BACK,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_FRONT      = VGA_V_FRONT,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BACK       = VGA_V_BACK,
  parameter int READ_LATENCY = VGA_READ_LATENCY
) (
  input  logic               clock,
  input  logic               reset,
  output logic               fb_req,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  input  logic [23:0]        fb_data,
  output logic               rgb_hs,
  output logic               rgb_vs,
  output logic               rgb_de,
  output logic [7:0]         rgb_r,
  output logic [7:0]         rgb_g,
  output logic [7:0]         rgb_b,
  output logic               frame_start,
  output logic               line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  localparam logic [COORD_W:0] H_ACT_W = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0] V_ACT_W = (COORD_W+1)'(V_ACTIVE);
  localparam logic [COORD_W:0] H_SYNC_LO = (COORD_W+1)'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W:0] H_SYNC_HI = (COORD_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_W:0] V_SYNC_LO = (COORD_W+1)'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W:0] V_SYNC_HI = (COORD_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("video_timing_gen: READ_LATENCY %0d outside 1..4", READ_LATENCY);
  end
  if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL %0d / V_TOTAL %0d exceed 10-bit counters",
           H_TOTAL, V_TOTAL);
  end

  logic [COORD_W-1:0] hcnt;
  logic [COORD_W-1:0] vcnt;
  logic               h_wrap;
  logic               v_wrap;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  // hcnt/vcnt name the pixel that stage 0 will hold after the next edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= h_wrap ? '0 : hcnt + COORD_W'(1);
      if (h_wrap) begin
        vcnt <= v_wrap ? '0 : vcnt + COORD_W'(1);
      end
    end
  end

  video_ctrl_t ctrl_raw;

  always_comb begin
    ctrl_raw             = '0;
    ctrl_raw.de          = ({1'b0, hcnt} < H_ACT_W) && ({1'b0, vcnt} < V_ACT_W);
    ctrl_raw.hs          = in_window(hcnt, H_SYNC_LO, H_SYNC_HI);
    ctrl_raw.vs          = in_window(vcnt, V_SYNC_LO, V_SYNC_HI);
    ctrl_raw.frame_start = (hcnt == '0) && (vcnt == '0);
    ctrl_raw.line_start  = (hcnt == '0);
  end

  // Stage 0. fb_req is a fire-and-forget strobe with no ready/backpressure:
  // the framebuffer must present fb_data exactly READ_LATENCY cycles after it.
  video_ctrl_t ctrl_s0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_s0 <= '0;
      fb_req  <= 1'b0;
      fb_x    <= '0;
      fb_y    <= '0;
    end else begin
      ctrl_s0 <= ctrl_raw;
      fb_req  <= ctrl_raw.de;
      if (ctrl_raw.de) begin
        fb_x <= hcnt;
        fb_y <= vcnt;
      end
    end
  end

  video_ctrl_t ctrl_dly;

  video_ctrl_delay #(
    .DEPTH (READ_LATENCY)
  ) u_ctrl_delay (
    .clock (clock),
    .reset (reset),
    .din   (ctrl_s0),
    .dout  (ctrl_dly)
  );

  // ctrl_dly and fb_data refer to the same pixel here; register them together
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_hs      <= 1'b0;
      rgb_vs      <= 1'b0;
      rgb_de      <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      rgb_r       <= '0;
      rgb_g       <= '0;
      rgb_b       <= '0;
    end else begin
      rgb_hs      <= ctrl_dly.hs;
      rgb_vs      <= ctrl_dly.vs;
      rgb_de      <= ctrl_dly.de;
      frame_start <= ctrl_dly.frame_start;
      line_start  <= ctrl_dly.line_start;
      {rgb_r, rgb_g, rgb_b} <= ctrl_dly.de ? fb_data : 24'h0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: several timing/latency configurations checked cycle by
// cycle against an arithmetic model of the raster, plus reset and edge-pixel scenarios.
module tb_video_timing_gen;

  localparam int NCFG = 5;
  // 0: 640x480 RL2, 1: 64x48 RL2, 2: 64x48 RL1, 3: 64x48 RL4, 4: tiny 4x2 RL2
  localparam int HA_T [NCFG] = '{640, 64, 64, 64, 4};
  localparam int HF_T [NCFG] = '{ 16,  4,  4,  4, 1};
  localparam int HS_T [NCFG] = '{ 96,  8,  8,  8, 1};
  localparam int HB_T [NCFG] = '{ 48,  4,  4,  4, 1};
  localparam int VA_T [NCFG] = '{480, 48, 48, 48, 2};
  localparam int VF_T [NCFG] = '{ 10,  3,  3,  3, 1};
  localparam int VS_T [NCFG] = '{  2,  2,  2,  2, 1};
  localparam int VB_T [NCFG] = '{ 33,  5,  5,  5, 1};
  localparam int RL_T [NCFG] = '{  2,  2,  1,  4, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NCFG-1:0]        rst;
  logic [NCFG-1:0]        fb_req, hs, vs, de, fs, ls;
  logic [NCFG-1:0][9:0]   fb_x, fb_y;
  logic [NCFG-1:0][23:0]  rgb;

  int tests;
  int fails;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int RL = RL_T[g];
    logic [23:0] fb_pipe [RL];
    logic [23:0] fb_data;
    logic [7:0]  r_o, g_o, b_o;

    // Framebuffer model: {x,y,5A} for requested pixels, random junk otherwise
    always @(posedge clk) begin
      fb_pipe[0] <= fb_req[g] ? {fb_x[g][7:0], fb_y[g][7:0], 8'h5A} : 24'($urandom);
      for (int i = 1; i < RL; i++) fb_pipe[i] <= fb_pipe[i-1];
    end
    assign fb_data = fb_pipe[RL-1];

    video_timing_gen #(
      .H_ACTIVE(HA_T[g]), .H_FRONT(HF_T[g]), .H_SYNC(HS_T[g]), .H_BACK(HB_T[g]),
      .V_ACTIVE(VA_T[g]), .V_FRONT(VF_T[g]), .V_SYNC(VS_T[g]), .V_BACK(VB_T[g]),
      .READ_LATENCY(RL)
    ) u_dut (
      .clock       (clk),
      .reset       (rst[g]),
      .fb_req      (fb_req[g]),
      .fb_x        (fb_x[g]),
      .fb_y        (fb_y[g]),
      .fb_data     (fb_data),
      .rgb_hs      (hs[g]),
      .rgb_vs      (vs[g]),
      .rgb_de      (de[g]),
      .rgb_r       (r_o),
      .rgb_g       (g_o),
      .rgb_b       (b_o),
      .frame_start (fs[g]),
      .line_start  (ls[g])
    );
    assign rgb[g] = {r_o, g_o, b_o};
  end

  function automatic int h_total(input int k);
    return HA_T[k] + HF_T[k] + HS_T[k] + HB_T[k];
  endfunction

  function automatic int v_total(input int k);
    return VA_T[k] + VF_T[k] + VS_T[k] + VB_T[k];
  endfunction

  // Leaves reset released #1 after an edge; the next edge loads pixel (0,0)
  task automatic reset_dut(input int k);
    @(posedge clk); #1 rst[k] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst[k] = 1'b0;
  endtask

  task automatic test_reset(input int k);
    logic [49:0] got;
    @(posedge clk); #1 rst[k] = 1'b1; #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      got = {fb_req[k], fb_x[k], fb_y[k], hs[k], vs[k], de[k], fs[k], ls[k], rgb[k]};
      tests++;
      if (got !== '0) begin
        fails++;
        $display("FAIL reset_outputs cfg%0d step %0d: got %h expected 0", k, c, got);
      end
    end
    rst[k] = 1'b0;
  endtask

  task automatic test_timing(input int k, input int ncyc);
    int ha, va, hf, vf, hsw, vsw, ht, vt, rl, frame_len;
    int h, v, p;
    int fs_cnt, ls_cnt, de_cnt, hs_line, vs_run, vs_max;
    logic [9:0]  last_x, last_y;
    logic        exp_req;
    logic [28:0] exp_o, got_o;
    ha = HA_T[k]; va = VA_T[k]; hf = HF_T[k]; vf = VF_T[k];
    hsw = HS_T[k]; vsw = VS_T[k]; rl = RL_T[k];
    ht = h_total(k); vt = v_total(k); frame_len = ht * vt;
    fs_cnt = 0; ls_cnt = 0; de_cnt = 0; hs_line = 0; vs_run = 0; vs_max = 0;
    last_x = '0; last_y = '0;
    reset_dut(k);
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk); #1;
      h = n % ht; v = (n / ht) % vt;
      exp_req = (h < ha) && (v < va);
      if (exp_req) begin last_x = 10'(h); last_y = 10'(v); end
      tests++;
      if ({fb_req[k], fb_x[k], fb_y[k]} !== {exp_req, last_x, last_y}) begin
        fails++;
        $display("FAIL fb_port cfg%0d n=%0d: got req=%0d x=%0d y=%0d, expected req=%0d x=%0d y=%0d",
                 k, n, fb_req[k], fb_x[k], fb_y[k], exp_req, last_x, last_y);
      end
      exp_o = '0;
      if (n > rl) begin
        p = n - rl - 1; h = p % ht; v = (p / ht) % vt;
        exp_o[28] = (h >= ha + hf) && (h < ha + hf + hsw);
        exp_o[27] = (v >= va + vf) && (v < va + vf + vsw);
        exp_o[26] = (h < ha) && (v < va);
        exp_o[25] = (h == 0) && (v == 0);
        exp_o[24] = (h == 0);
        if (exp_o[26]) exp_o[23:0] = {8'(h), 8'(v), 8'h5A};
        if (p < frame_len) begin
          fs_cnt += int'(fs[k]); ls_cnt += int'(ls[k]); de_cnt += int'(de[k]);
          hs_line += int'(hs[k]);
          vs_run = vs[k] ? vs_run + 1 : 0;
          if (vs_run > vs_max) vs_max = vs_run;
          if (h == ht - 1) begin
            tests++;
            if (hs_line != hsw) begin
              fails++;
              $display("FAIL hs_per_line cfg%0d line %0d: got %0d expected %0d", k, v, hs_line, hsw);
            end
            hs_line = 0;
          end
        end
      end
      got_o = {hs[k], vs[k], de[k], fs[k], ls[k], rgb[k]};
      tests++;
      if (got_o !== exp_o) begin
        fails++;
        $display("FAIL outputs cfg%0d n=%0d (hs,vs,de,fs,ls,rgb): got %h expected %h", k, n, got_o, exp_o);
      end
    end
    if (ncyc > frame_len + rl) begin
      tests += 4;
      if (fs_cnt != 1) begin
        fails++; $display("FAIL frame_start_count cfg%0d: got %0d expected 1", k, fs_cnt);
      end
      if (ls_cnt != vt) begin
        fails++; $display("FAIL line_start_count cfg%0d: got %0d expected %0d", k, ls_cnt, vt);
      end
      if (de_cnt != ha * va) begin
        fails++; $display("FAIL de_count cfg%0d: got %0d expected %0d", k, de_cnt, ha * va);
      end
      if (vs_max != vsw * ht) begin
        fails++; $display("FAIL vs_run cfg%0d: got %0d expected %0d", k, vs_max, vsw * ht);
      end
    end
  endtask

  task automatic test_edge_pixel(input int k);
    int bound, n;
    logic done, seen;
    logic [23:0] prev_rgb, exp_last;
    bound = 2 * h_total(k) * v_total(k);
    exp_last = {8'(HA_T[k] - 1), 8'(VA_T[k] - 1), 8'h5A};
    done = 1'b0; seen = 1'b0; prev_rgb = '0; n = 0;
    reset_dut(k);
    while (!done && n < bound) begin
      @(posedge clk); #1; n++;
      if (de[k] && fs[k] && seen) begin
        done = 1'b0 | 1'b1;
        tests += 2;
        if (prev_rgb !== exp_last) begin
          fails++;
          $display("FAIL last_active_pixel cfg%0d: got %h expected %h", k, prev_rgb, exp_last);
        end
        if ({ls[k], rgb[k]} !== {1'b1, 24'h00005A}) begin
          fails++;
          $display("FAIL wrap_pixel cfg%0d: got ls=%0d rgb=%h expected ls=1 rgb=00005a", k, ls[k], rgb[k]);
        end
      end else if (de[k]) begin
        prev_rgb = rgb[k];
        seen = 1'b1;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL edge_pixel_timeout cfg%0d: got no frame wrap in %0d cycles expected one", k, bound);
    end
  endtask

  task automatic test_mid_frame_reset(input int k);
    int rl, target;
    logic [49:0] got;
    logic [28:0] got_o;
    rl = RL_T[k];
    target = 20 * h_total(k) + 30 + int'($urandom_range(0, 20));
    reset_dut(k);
    repeat (target) @(posedge clk);
    #1 rst[k] = 1'b1; #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      got = {fb_req[k], fb_x[k], fb_y[k], hs[k], vs[k], de[k], fs[k], ls[k], rgb[k]};
      tests++;
      if (got !== '0) begin
        fails++;
        $display("FAIL mid_reset_outputs cfg%0d step %0d: got %h expected 0", k, c, got);
      end
    end
    rst[k] = 1'b0;
    for (int n = 0; n <= rl + 1; n++) begin
      @(posedge clk); #1;
      got_o = {hs[k], vs[k], de[k], fs[k], ls[k], rgb[k]};
      tests++;
      if (n <= rl) begin
        if (got_o !== '0) begin
          fails++;
          $display("FAIL post_reset_quiet cfg%0d n=%0d: got %h expected 0", k, n, got_o);
        end
      end else if ({de[k], fs[k], ls[k]} !== 3'b111) begin
        fails++;
        $display("FAIL post_reset_first_pixel cfg%0d: got de=%0d fs=%0d ls=%0d expected 1 1 1",
                 k, de[k], fs[k], ls[k]);
      end
    end
  endtask

  task automatic test_hs_phase(input int k, input int lines);
    logic [31:0] exp_q[$];
    logic [31:0] exp_t;
    logic prev_hs;
    int ncyc;
    ncyc = lines * h_total(k) + HA_T[k] + HF_T[k] + RL_T[k] + 2;
    prev_hs = 1'b0;
    exp_q.delete();
    reset_dut(k);
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk); #1;
      if (fb_req[k] && fb_x[k] == 10'd0)
        exp_q.push_back(32'(n + HA_T[k] + HF_T[k] + RL_T[k] + 1));
      if (hs[k] && !prev_hs) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL hs_rise cfg%0d: got rise at %0d expected none", k, n);
        end else begin
          exp_t = exp_q.pop_front();
          if (32'(n) != exp_t) begin
            fails++;
            $display("FAIL hs_rise cfg%0d: got rise at %0d expected %0d", k, n, exp_t);
          end
        end
      end
      prev_hs = hs[k];
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL hs_rise_missing cfg%0d: got %0d unmatched line starts expected 0", k, exp_q.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = '1;
    repeat (2) @(posedge clk);
    #1 rst = '0;

    test_reset(0);
    test_hs_phase(0, 2);
    test_timing(0, 2 * h_total(0) + 20);

    test_reset(1);
    test_timing(1, h_total(1) * v_total(1) + 10);
    test_edge_pixel(1);
    test_mid_frame_reset(1);

    test_timing(2, h_total(2) * v_total(2) + 10);
    test_hs_phase(2, 6);
    test_mid_frame_reset(2);

    test_timing(3, h_total(3) * v_total(3) + 10);
    test_hs_phase(3, 6);
    test_mid_frame_reset(3);

    test_reset(4);
    test_timing(4, 3 * h_total(4) * v_total(4) + 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time limit expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
